pc_fetch_ctrl: RTL

- Fetch-stage sequencer; owns the PC register and drives the PC+4 increment path.
- Selects next PC from sequential, branch/jump redirect or trap vector.
- Runs the single-outstanding instruction-memory request/grant/response handshake.
- Presents InstrF/PCF to the F/D pipeline register under hazard-unit stall control.

---
 rtl/pc_fetch_ctrl.sv | 96 +++++++++
 1 files changed

// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - fetch-stage PC sequencer with single-outstanding imem handshake
module pc_fetch_ctrl #(
    parameter logic [63:0] RESET_PC  = 64'h0000_0000_8000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        PCSrcE,
    input  logic [63:0] PCTargetE,
    input  logic        trap_valid,
    input  logic [63:0] trap_vector,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [63:0] PCF,
    output logic [63:0] PCPlus4F,
    output logic [31:0] InstrF,
    output logic        InstrValidF,
    output logic        misalign_exc
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t      state;
    logic        misaligned;
    logic        redirect;
    logic [63:0] target;

    // A misaligned branch target is dropped here; traps are realigned and always win.
    always_comb begin
        misaligned = PCSrcE && !trap_valid && (PCTargetE[1:0] != 2'b00);
        redirect   = trap_valid || (PCSrcE && !misaligned);
        target     = trap_valid ? (trap_vector & ~64'h3) : PCTargetE;
    end

    assign PCPlus4F  = PCF + 64'd4;
    assign imem_addr = PCF;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            PCF          <= RESET_PC;
            imem_req     <= 1'b0;
            InstrF       <= NOP_INSTR;
            InstrValidF  <= 1'b0;
            misalign_exc <= 1'b0;
        end else begin
            misalign_exc <= misaligned;
            case (state)
                IDLE: begin
                    if (redirect) PCF <= target;
                    state    <= REQ;
                    imem_req <= 1'b1;
                end
                REQ: begin
                    if (redirect) PCF <= target;
                    if (imem_gnt) begin
                        state    <= redirect ? DROP : WAIT;
                        imem_req <= 1'b0;
                    end
                end
                WAIT: begin
                    if (InstrValidF) begin
                        if (redirect || !StallF) begin
                            PCF         <= redirect ? target : PCPlus4F;
                            InstrValidF <= 1'b0;
                            InstrF      <= NOP_INSTR;
                            state       <= REQ;
                            imem_req    <= 1'b1;
                        end
                    end else if (redirect) begin
                        // A response arriving with the redirect is simply thrown away.
                        PCF      <= target;
                        state    <= imem_rvalid ? REQ : DROP;
                        imem_req <= imem_rvalid;
                    end else if (imem_rvalid) begin
                        InstrF      <= imem_rdata;
                        InstrValidF <= 1'b1;
                    end
                end
                DROP: begin
                    if (redirect) PCF <= target;
                    if (imem_rvalid) begin
                        state    <= REQ;
                        imem_req <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
